fetch_scheduler: RTL and testbench

Command sequencer in front of the input-feature and weight fetch units. It accepts multi-line fetch commands from the top FSM into a small queue. It expands each command into one single-line fetch per line with incrementing addresses, pulses the matching fetch unit's enable, and waits for that unit's `fetch_done`. Only one fetch unit is active at a time. The block reports per-command completion, idle status and sticky errors back to the top FSM.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_cmd_fifo.sv | 55 +++++
 rtl/fetch_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_fetch_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch command sequencer.
package fetch_pkg;

   // Command type encodings accepted from the top FSM.
   localparam logic [7:0] FETCH_FEATURE = 8'h01;
   localparam logic [7:0] FETCH_WEIGHT  = 8'h02;

   // Sequencer FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } fetch_state_e;

   // One queued command: 48 bits.
   typedef struct packed {
      logic [7:0]  cmd_type;
      logic [15:0] src;
      logic [7:0]  dst;
      logic [7:0]  mem_sel;
      logic [7:0]  len;
   } fetch_cmd_t;

endpackage

// File: rtl/fetch_cmd_fifo.sv
// Command queue: registered FIFO of fetch_cmd_t. The head entry becomes
// visible the cycle after it is written (no fall-through). A push is
// refused whenever the FIFO is full, regardless of a same-cycle pop.
module fetch_cmd_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  fetch_cmd_t push_data_i,
   input  logic       pop_i,
   output fetch_cmd_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   fetch_cmd_t       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage write; contents need no reset since empty_o guards reads.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/fetch_scheduler.sv
// Fetch command sequencer: queues multi-line commands, expands each into
// single-line fetches with incrementing addresses, and drives one fetch
// unit at a time, waiting for its done pulse (with a timeout).
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on queue occupancy, never
// on cmd_valid, and cmd_valid may be raised or dropped on any cycle.
module fetch_scheduler
   import fetch_pkg::*;
#(
   parameter int QUEUE_DEPTH  = 4,
   parameter int DONE_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [7:0]   cmd_type,
   input  logic [15:0]  cmd_src_addr,
   input  logic [7:0]   cmd_dst_addr,
   input  logic [7:0]   cmd_mem_sel,
   input  logic [7:0]   cmd_len,
   output logic         feature_fetch_enable,
   output logic [15:0]  feat_src_addr,
   output logic [7:0]   feat_dst_addr,
   output logic [7:0]   feat_mem_sel,
   input  logic         feat_fetch_done,
   output logic         weight_fetch_enable,
   output logic [15:0]  wgt_src_addr,
   output logic [7:0]   wgt_dst_addr,
   input  logic         wgt_fetch_done,
   output logic         cmd_done,
   output logic         idle,
   output logic         err_bad_type,
   output logic         err_timeout,
   output fetch_state_e dbg_state
);

   localparam int         TW       = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

   fetch_cmd_t   push_cmd, head_cmd;
   logic         fifo_full, fifo_empty, pop;

   fetch_state_e state_q, state_d;
   logic         cur_wgt_q, cur_wgt_d;
   logic [15:0]  cur_src_q, cur_src_d;
   logic [7:0]   cur_dst_q, cur_dst_d;
   logic [7:0]   cur_mem_sel_q, cur_mem_sel_d;
   logic [7:0]   lines_left_q, lines_left_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic         feat_en_q, feat_en_d;
   logic         wgt_en_q, wgt_en_d;
   logic [15:0]  feat_src_q, feat_src_d;
   logic [7:0]   feat_dst_q, feat_dst_d;
   logic [7:0]   feat_mem_sel_q, feat_mem_sel_d;
   logic [15:0]  wgt_src_q, wgt_src_d;
   logic [7:0]   wgt_dst_q, wgt_dst_d;
   logic         cmd_done_q, cmd_done_d;
   logic         err_bad_type_q, err_bad_type_d;
   logic         err_timeout_q, err_timeout_d;
   logic         active_done;
   logic [15:0]  next_src;
   logic [7:0]   next_dst;

   assign push_cmd = '{cmd_type: cmd_type, src: cmd_src_addr, dst: cmd_dst_addr,
                       mem_sel: cmd_mem_sel, len: cmd_len};

   fetch_cmd_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (cmd_valid),
      .push_data_i (push_cmd),
      .pop_i       (pop),
      .head_o      (head_cmd),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Next-state and datapath: enables are registered, so they are raised on
   // the transition into ISSUE and are high for exactly the ISSUE cycle.
   always_comb begin
      state_d        = state_q;
      cur_wgt_d      = cur_wgt_q;
      cur_src_d      = cur_src_q;
      cur_dst_d      = cur_dst_q;
      cur_mem_sel_d  = cur_mem_sel_q;
      lines_left_d   = lines_left_q;
      tmo_d          = tmo_q;
      feat_en_d      = 1'b0;
      wgt_en_d       = 1'b0;
      feat_src_d     = feat_src_q;
      feat_dst_d     = feat_dst_q;
      feat_mem_sel_d = feat_mem_sel_q;
      wgt_src_d      = wgt_src_q;
      wgt_dst_d      = wgt_dst_q;
      cmd_done_d     = 1'b0;
      err_bad_type_d = err_bad_type_q;
      err_timeout_d  = err_timeout_q;
      pop            = 1'b0;
      active_done    = cur_wgt_q ? wgt_fetch_done : feat_fetch_done;
      next_src       = cur_src_q + 16'd1;
      next_dst       = cur_dst_q + 8'd1;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop           = 1'b1;
               cur_src_d     = head_cmd.src;
               cur_dst_d     = head_cmd.dst;
               cur_mem_sel_d = head_cmd.mem_sel;
               lines_left_d  = head_cmd.len;
               if (head_cmd.cmd_type == FETCH_FEATURE) begin
                  cur_wgt_d      = 1'b0;
                  feat_en_d      = 1'b1;
                  feat_src_d     = head_cmd.src;
                  feat_dst_d     = head_cmd.dst;
                  feat_mem_sel_d = head_cmd.mem_sel;
                  state_d        = ST_ISSUE;
               end else if (head_cmd.cmd_type == FETCH_WEIGHT) begin
                  cur_wgt_d = 1'b1;
                  wgt_en_d  = 1'b1;
                  wgt_src_d = head_cmd.src;
                  wgt_dst_d = head_cmd.dst;
                  state_d   = ST_ISSUE;
               end else begin
                  // Illegal type: retire the command without touching any unit.
                  err_bad_type_d = 1'b1;
                  cmd_done_d     = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (active_done) begin
               if (lines_left_q == 8'd0) begin
                  cmd_done_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  cur_src_d    = next_src;
                  cur_dst_d    = next_dst;
                  lines_left_d = lines_left_q - 8'd1;
                  if (cur_wgt_q) begin
                     wgt_en_d  = 1'b1;
                     wgt_src_d = next_src;
                     wgt_dst_d = next_dst;
                  end else begin
                     feat_en_d      = 1'b1;
                     feat_src_d     = next_src;
                     feat_dst_d     = next_dst;
                     feat_mem_sel_d = cur_mem_sel_q;
                  end
                  state_d = ST_ISSUE;
               end
            end else if (tmo_q == TMO_LAST) begin
               // Unit never answered: abandon the remaining lines.
               err_timeout_d = 1'b1;
               cmd_done_d    = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cur_wgt_q      <= 1'b0;
         cur_src_q      <= '0;
         cur_dst_q      <= '0;
         cur_mem_sel_q  <= '0;
         lines_left_q   <= '0;
         tmo_q          <= '0;
         feat_en_q      <= 1'b0;
         wgt_en_q       <= 1'b0;
         feat_src_q     <= '0;
         feat_dst_q     <= '0;
         feat_mem_sel_q <= '0;
         wgt_src_q      <= '0;
         wgt_dst_q      <= '0;
         cmd_done_q     <= 1'b0;
         err_bad_type_q <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cur_wgt_q      <= cur_wgt_d;
         cur_src_q      <= cur_src_d;
         cur_dst_q      <= cur_dst_d;
         cur_mem_sel_q  <= cur_mem_sel_d;
         lines_left_q   <= lines_left_d;
         tmo_q          <= tmo_d;
         feat_en_q      <= feat_en_d;
         wgt_en_q       <= wgt_en_d;
         feat_src_q     <= feat_src_d;
         feat_dst_q     <= feat_dst_d;
         feat_mem_sel_q <= feat_mem_sel_d;
         wgt_src_q      <= wgt_src_d;
         wgt_dst_q      <= wgt_dst_d;
         cmd_done_q     <= cmd_done_d;
         err_bad_type_q <= err_bad_type_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

   assign cmd_ready            = !fifo_full;
   assign idle                 = fifo_empty && (state_q == ST_IDLE);
   assign feature_fetch_enable = feat_en_q;
   assign feat_src_addr        = feat_src_q;
   assign feat_dst_addr        = feat_dst_q;
   assign feat_mem_sel         = feat_mem_sel_q;
   assign weight_fetch_enable  = wgt_en_q;
   assign wgt_src_addr         = wgt_src_q;
   assign wgt_dst_addr         = wgt_dst_q;
   assign cmd_done             = cmd_done_q;
   assign err_bad_type         = err_bad_type_q;
   assign err_timeout          = err_timeout_q;
   assign dbg_state            = state_q;

endmodule

// File: tb/tb_fetch_scheduler.sv
// Directed bench for fetch_scheduler. Cycle k is the clock period that
// starts at the k-th rising edge; a command accepted at edge a enables its
// unit in cycle a+1, done returns in a+4, and cmd_done follows in a+5.
module tb_fetch_scheduler;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [7:0]   cmd_type = '0;
   logic [15:0]  cmd_src_addr = '0;
   logic [7:0]   cmd_dst_addr = '0;
   logic [7:0]   cmd_mem_sel = '0;
   logic [7:0]   cmd_len = '0;
   logic         feature_fetch_enable;
   logic [15:0]  feat_src_addr;
   logic [7:0]   feat_dst_addr;
   logic [7:0]   feat_mem_sel;
   logic         feat_fetch_done = 1'b0;
   logic         weight_fetch_enable;
   logic [15:0]  wgt_src_addr;
   logic [7:0]   wgt_dst_addr;
   logic         wgt_fetch_done = 1'b0;
   logic         cmd_done;
   logic         idle;
   logic         err_bad_type;
   logic         err_timeout;
   fetch_state_e dbg_state;

   fetch_scheduler #(.QUEUE_DEPTH(4), .DONE_TIMEOUT(16)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .cmd_valid            (cmd_valid),
      .cmd_ready            (cmd_ready),
      .cmd_type             (cmd_type),
      .cmd_src_addr         (cmd_src_addr),
      .cmd_dst_addr         (cmd_dst_addr),
      .cmd_mem_sel          (cmd_mem_sel),
      .cmd_len              (cmd_len),
      .feature_fetch_enable (feature_fetch_enable),
      .feat_src_addr        (feat_src_addr),
      .feat_dst_addr        (feat_dst_addr),
      .feat_mem_sel         (feat_mem_sel),
      .feat_fetch_done      (feat_fetch_done),
      .weight_fetch_enable  (weight_fetch_enable),
      .wgt_src_addr         (wgt_src_addr),
      .wgt_dst_addr         (wgt_dst_addr),
      .wgt_fetch_done       (wgt_fetch_done),
      .cmd_done             (cmd_done),
      .idle                 (idle),
      .err_bad_type         (err_bad_type),
      .err_timeout          (err_timeout),
      .dbg_state            (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor: log enables and cmd_done ----------------
   typedef struct {
      int          cyc;
      bit          wgt;
      logic [15:0] src;
      logic [7:0]  dst;
      logic [7:0]  msel;
   } en_rec_t;

   en_rec_t en_log[$];
   int      done_log[$];
   int      feat_due = -1;
   int      wgt_due = -1;
   int      overlap = 0;

   always @(negedge clk) begin
      if (feature_fetch_enable) begin
         en_log.push_back('{cyc, 1'b0, feat_src_addr, feat_dst_addr, feat_mem_sel});
         feat_due = cyc + 3;
      end
      if (weight_fetch_enable) begin
         en_log.push_back('{cyc, 1'b1, wgt_src_addr, wgt_dst_addr, 8'h00});
         wgt_due = cyc + 3;
      end
      if (feature_fetch_enable && weight_fetch_enable) overlap++;
      if (cmd_done) done_log.push_back(cyc);
   end

   // ---------------- fetch unit model: done 3 cycles after enable ----------------
   bit resp_on = 1'b1;
   int force_feat = -1;
   int force_wgt = -1;

   always @(posedge clk) begin
      #1;
      feat_fetch_done = (resp_on && cyc == feat_due) || (cyc == force_feat);
      wgt_fetch_done  = (resp_on && cyc == wgt_due) || (cyc == force_wgt);
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic en_rec_t get_en(input int i);
      en_rec_t r;
      r = '{default: 0};
      if (i < en_log.size()) r = en_log[i];
      return r;
   endfunction

   function automatic int get_done(input int i);
      if (i < done_log.size()) return done_log[i];
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic clear_logs();
      en_log.delete();
      done_log.delete();
   endtask

   // Drive one command and hold it until accepted; returns the accept edge.
   task automatic send_cmd(input logic [7:0] t, input logic [15:0] s, input logic [7:0] d,
                           input logic [7:0] m, input logic [7:0] l, output int acc);
      bit ok;
      cmd_valid    = 1'b1;
      cmd_type     = t;
      cmd_src_addr = s;
      cmd_dst_addr = d;
      cmd_mem_sel  = m;
      cmd_len      = l;
      acc = -1;
      for (int t_i = 0; t_i < 100; t_i++) begin
         ok = cmd_ready;
         tick(1);
         if (ok) begin
            acc = cyc;
            break;
         end
      end
      cmd_valid = 1'b0;
      if (acc < 0) check("accept_bound", 32'd0, 32'd1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int a, b, f, acc6;
      int acc[5];
      en_rec_t r;
      logic [15:0] w_src[3];
      logic [7:0]  w_dst[3];

      // Reset state
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      check("rst_feat_en", 32'(feature_fetch_enable), 32'd0);
      check("rst_wgt_en", 32'(weight_fetch_enable), 32'd0);
      check("rst_cmd_done", 32'(cmd_done), 32'd0);
      check("rst_err_bad", 32'(err_bad_type), 32'd0);
      check("rst_err_tmo", 32'(err_timeout), 32'd0);
      check("rst_feat_src", 32'(feat_src_addr), 32'd0);
      check("rst_wgt_src", 32'(wgt_src_addr), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      tick(2);

      // Single-line feature fetch
      clear_logs();
      send_cmd(FETCH_FEATURE, 16'h0100, 8'h10, 8'h01, 8'd0, a);
      check("t1_idle_busy", 32'(idle), 32'd0);
      tick(10);
      r = get_en(0);
      check("t1_en_count", en_log.size(), 32'd1);
      check("t1_en_cyc", r.cyc, a + 1);
      check("t1_en_type", 32'(r.wgt), 32'd0);
      check("t1_src", 32'(r.src), 32'h0100);
      check("t1_dst", 32'(r.dst), 32'h10);
      check("t1_msel", 32'(r.msel), 32'h01);
      check("t1_done_count", done_log.size(), 32'd1);
      check("t1_done_cyc", get_done(0), a + 5);
      check("t1_idle", 32'(idle), 32'd1);

      // Multi-line weight fetch with address wrap
      clear_logs();
      w_src = '{16'hFFFE, 16'hFFFF, 16'h0000};
      w_dst = '{8'hFF, 8'h00, 8'h01};
      send_cmd(FETCH_WEIGHT, 16'hFFFE, 8'hFF, 8'h00, 8'd2, a);
      tick(18);
      check("t2_en_count", en_log.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         r = get_en(i);
         check("t2_en_cyc", r.cyc, a + 1 + 4 * i);
         check("t2_en_type", 32'(r.wgt), 32'd1);
         check("t2_src", 32'(r.src), 32'(w_src[i]));
         check("t2_dst", 32'(r.dst), 32'(w_dst[i]));
      end
      check("t2_done_count", done_log.size(), 32'd1);
      check("t2_done_cyc", get_done(0), a + 13);
      check("t2_feat_src_held", 32'(feat_src_addr), 32'h0100);

      // Illegal type followed by a legal command
      clear_logs();
      send_cmd(8'h07, 16'hAAAA, 8'hAA, 8'h00, 8'd0, a);
      send_cmd(FETCH_FEATURE, 16'h0200, 8'h20, 8'h00, 8'd0, b);
      check("t3_acc2", b, a + 1);
      tick(10);
      r = get_en(0);
      check("t3_en_count", en_log.size(), 32'd1);
      check("t3_en_cyc", r.cyc, a + 2);
      check("t3_src", 32'(r.src), 32'h0200);
      check("t3_done_count", done_log.size(), 32'd2);
      check("t3_done_bad", get_done(0), a + 1);
      check("t3_done_good", get_done(1), a + 6);
      check("t3_err_bad", 32'(err_bad_type), 32'd1);
      check("t3_err_tmo", 32'(err_timeout), 32'd0);

      // Timeout with a stray done from the inactive unit
      clear_logs();
      resp_on = 1'b0;
      send_cmd(FETCH_FEATURE, 16'h0300, 8'h30, 8'h01, 8'd3, a);
      force_wgt = a + 4;
      wait_until(a + 17);
      check("t4_tmo_early", 32'(err_timeout), 32'd0);
      check("t4_done_early", 32'(cmd_done), 32'd0);
      tick(1);
      check("t4_tmo_set", 32'(err_timeout), 32'd1);
      check("t4_done_pulse", 32'(cmd_done), 32'd1);
      tick(8);
      check("t4_en_count", en_log.size(), 32'd1);
      check("t4_en_cyc", get_en(0).cyc, a + 1);
      check("t4_done_count", done_log.size(), 32'd1);
      check("t4_tmo_sticky", 32'(err_timeout), 32'd1);
      check("t4_bad_sticky", 32'(err_bad_type), 32'd1);

      // Queue full while the first command stalls
      clear_logs();
      for (int i = 0; i < 5; i++)
         send_cmd(FETCH_FEATURE, 16'h0400 + 16'(i), 8'h40 + 8'(i), 8'(i % 2), 8'd0, acc[i]);
      check("t5_acc_last", acc[4], acc[0] + 4);
      check("t5_ready_full", 32'(cmd_ready), 32'd0);
      tick(2);
      check("t5_ready_held", 32'(cmd_ready), 32'd0);
      f = cyc + 1;
      force_feat = f;
      send_cmd(FETCH_FEATURE, 16'h0405, 8'h45, 8'h01, 8'd0, acc6);
      check("t5_acc6", acc6, f + 3);
      resp_on = 1'b1;
      tick(40);
      for (int i = 0; i < 6; i++) exp_q.push_back(32'h0400 + 32'(i));
      check("t5_en_count", en_log.size(), 32'd6);
      check("t5_en0_cyc", get_en(0).cyc, acc[0] + 1);
      for (int k = 0; k < 6; k++) begin
         r = get_en(k);
         check("t5_src_order", 32'(r.src), exp_q.pop_front());
         if (k > 0) begin
            check("t5_en_cyc", r.cyc, f + 2 + 5 * (k - 1));
            check("t5_done_cyc", get_done(k), f + 6 + 5 * (k - 1));
         end
      end
      check("t5_done_count", done_log.size(), 32'd6);
      check("t5_done0", get_done(0), f + 1);
      check("t5_idle", 32'(idle), 32'd1);

      // Reset in the middle of a multi-line command with another queued
      clear_logs();
      send_cmd(FETCH_FEATURE, 16'h0500, 8'h50, 8'h01, 8'd5, a);
      send_cmd(FETCH_FEATURE, 16'h0600, 8'h60, 8'h00, 8'd0, b);
      wait_until(a + 6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t6_feat_en", 32'(feature_fetch_enable), 32'd0);
      check("t6_wgt_en", 32'(weight_fetch_enable), 32'd0);
      check("t6_idle", 32'(idle), 32'd1);
      check("t6_ready", 32'(cmd_ready), 32'd1);
      check("t6_cmd_done", 32'(cmd_done), 32'd0);
      check("t6_feat_src", 32'(feat_src_addr), 32'd0);
      check("t6_feat_dst", 32'(feat_dst_addr), 32'd0);
      check("t6_feat_msel", 32'(feat_mem_sel), 32'd0);
      check("t6_wgt_src", 32'(wgt_src_addr), 32'd0);
      check("t6_wgt_dst", 32'(wgt_dst_addr), 32'd0);
      check("t6_err_bad", 32'(err_bad_type), 32'd0);
      check("t6_err_tmo", 32'(err_timeout), 32'd0);
      tick(12);
      check("t6_en_count", en_log.size(), 32'd2);
      check("t6_line2_src", 32'(get_en(1).src), 32'h0501);
      check("t6_no_done", done_log.size(), 32'd0);
      check("t6_idle_after", 32'(idle), 32'd1);

      check("one_unit_active", overlap, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
